// File: rtl/garage_door_ctrl.sv
// Garage-door motor FSM: one Activate button, two limit switches, travel timeout.
// Latency: one CLK edge from inputs to UP_M/DN_M (registered Moore outputs, no comb path).
// Backpressure: none; level-sensitive inputs are sampled every cycle. Optional macro GARAGE_OBSTRUCT_EN adds Obstruct.
module garage_door_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic CLK,
    input  logic RST,
    input  logic Activate,
    input  logic UP_Max,
    input  logic DN_Max,
`ifdef GARAGE_OBSTRUCT_EN
    input  logic Obstruct,
`endif
    output logic UP_M,
    output logic DN_M
);

    // A zero timeout still needs a legal (unused) one-bit counter.
    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MV_UP = 2'b01,
        MV_DN = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            up_m_q, dn_m_q;
    logic            obs;
    logic            timeout_hit;
    logic            fault;

`ifdef GARAGE_OBSTRUCT_EN
    assign obs = Obstruct;
`else
    assign obs = 1'b0;
`endif

    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);
    assign fault       = UP_Max && DN_Max;

    // Next-state and travel-counter rules; the unused encoding falls back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Activate && !fault) begin
                    if (DN_Max)
                        state_d = MV_UP;
                    else if (!obs)
                        state_d = MV_DN;
                end
            end
            MV_UP: begin
                if (UP_Max || timeout_hit)
                    state_d = IDLE;
            end
            MV_DN: begin
                // An obstruction outranks both the lower limit and the timeout.
                if (obs)
                    state_d = MV_UP;
                else if (DN_Max || timeout_hit)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE)
            cnt_d = '0;
        else if (state_d != state_q)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    // State, counter and Moore output registers; reset stops the motor immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            up_m_q  <= 1'b0;
            dn_m_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            up_m_q  <= (state_d == MV_UP);
            dn_m_q  <= (state_d == MV_DN);
        end
    end

    assign UP_M = up_m_q;
    assign DN_M = dn_m_q;

endmodule

// File: tb/tb_garage_door_ctrl.sv
// Self-checking bench for garage_door_ctrl (built with TIMEOUT_CYCLES=8).
// Latency: outputs sampled 1 time unit after each rising CLK edge.
// Backpressure: none; inputs change right after the sample point.
module tb_garage_door_ctrl;

    localparam int unsigned TO = 8;

    logic CLK, RST, Activate, UP_Max, DN_Max, UP_M, DN_M;
    logic Obstruct;

    garage_door_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Activate (Activate),
        .UP_Max   (UP_Max),
        .DN_Max   (DN_Max),
`ifdef GARAGE_OBSTRUCT_EN
        .Obstruct (Obstruct),
`endif
        .UP_M     (UP_M),
        .DN_M     (DN_M)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string name;
        bit    act;
        bit    upmax;
        bit    dnmax;
        bit    exp_up;
        bit    exp_dn;
    } vec_t;

    vec_t vecs[12];

    // Reference model: motion direction (+1 up, -1 down, 0 stopped) and the
    // number of cycles the motor has been running in the current direction.
    int m_dir = 0;
    int m_run = 0;

    function automatic void model_reset();
        m_dir = 0;
        m_run = 0;
    endfunction

    function automatic void model_step(bit act, bit um, bit dm, bit ob);
        if (m_dir == 0) begin
            if (act && !(um && dm)) begin
                if (dm) begin
                    m_dir = 1;  m_run = 1;
                end else if (!ob) begin
                    m_dir = -1; m_run = 1;
                end
            end
        end else if (m_dir == 1) begin
            if (um || m_run >= TO) m_dir = 0;
            else m_run++;
        end else begin
            if (ob) begin
                m_dir = 1; m_run = 1;
            end else if (dm || m_run >= TO) m_dir = 0;
            else m_run++;
        end
    endfunction

    task automatic check(string name, bit exp_up, bit exp_dn);
        n_checks++;
        if (UP_M !== exp_up || DN_M !== exp_dn) begin
            n_errors++;
            $display("FAIL %s: got UP_M=%b DN_M=%b, expected UP_M=%b DN_M=%b at %0t",
                     name, UP_M, DN_M, exp_up, exp_dn, $time);
        end
    endtask

    // Apply inputs, take one rising edge, sample just after it.
    task automatic step(bit act, bit um, bit dm, bit ob);
        Activate = act;
        UP_Max   = um;
        DN_Max   = dm;
        Obstruct = ob;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        Activate = 1'b0; UP_Max = 1'b0; DN_Max = 1'b0; Obstruct = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        model_reset();
    endtask

    initial begin
        RST = 1'b1;
        Activate = 1'b0; UP_Max = 1'b0; DN_Max = 1'b0; Obstruct = 1'b0;

        // Directed table, applied from reset in order.
        vecs[0]  = '{"open",            1, 0, 1, 1, 0};
        vecs[1]  = '{"up_ignores_act",  1, 0, 0, 1, 0};
        vecs[2]  = '{"stop_top",        0, 1, 0, 0, 0};
        vecs[3]  = '{"idle_no_act",     0, 1, 0, 0, 0};
        vecs[4]  = '{"close",           1, 1, 0, 0, 1};
        vecs[5]  = '{"dn_ignores_act",  1, 0, 0, 0, 1};
        vecs[6]  = '{"stop_bottom",     0, 0, 1, 0, 0};
        vecs[7]  = '{"midtravel_down",  1, 0, 0, 0, 1};
        vecs[8]  = '{"dn_wrong_limit",  0, 1, 0, 0, 1};
        vecs[9]  = '{"stop_bottom2",    1, 0, 1, 0, 0};
        vecs[10] = '{"act_held_reeval", 1, 0, 1, 1, 0};
        vecs[11] = '{"stop_top2",       0, 1, 0, 0, 0};

        #3;
        // Asynchronous reset with no clock edge in between.
        RST = 1'b0;
        #1;
        check("reset_async", 0, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        check("reset_state", 0, 0);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].act, vecs[i].upmax, vecs[i].dnmax, 1'b0);
            check(vecs[i].name, vecs[i].exp_up, vecs[i].exp_dn);
        end

        // Sensor fault: both limits high keeps the door idle.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 0);
            check("fault_hold", 0, 0);
        end

        // Timeout while opening: UP_M high for exactly TO samples.
        do_reset();
        step(1, 0, 1, 0);
        check("to_up_enter", 1, 0);
        for (int i = 1; i < TO; i++) begin
            step(0, 0, 0, 0);
            check("to_up_run", 1, 0);
        end
        step(0, 0, 0, 0);
        check("to_up_stop", 0, 0);
        step(0, 0, 0, 0);
        check("to_up_stays", 0, 0);

        // Timeout while closing, with Activate held: after the forced stop the
        // idle rules re-fire on the next edge and the door starts down again.
        do_reset();
        for (int i = 0; i < TO; i++) begin
            step(1, 0, 0, 0);
            check("to_dn_run", 0, 1);
        end
        step(1, 0, 0, 0);
        check("to_dn_stop", 0, 0);
        step(1, 0, 0, 0);
        check("to_dn_restart", 0, 1);

        // Limit and timeout coincide on the same edge.
        do_reset();
        step(1, 0, 1, 0);
        for (int i = 1; i < TO; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("limit_and_timeout", 0, 0);

        // Reset mid-travel stops the motor without a clock edge.
        do_reset();
        step(1, 0, 1, 0);
        check("pre_reset_moving", 1, 0);
        RST = 1'b0;
        #1;
        check("reset_midtravel", 0, 0);
        #2;
        RST = 1'b1;
        model_reset();

`ifdef GARAGE_OBSTRUCT_EN
        do_reset();
        step(1, 1, 0, 0);
        check("obs_pre_down", 0, 1);
        step(0, 0, 1, 1);
        check("obs_reverse", 1, 0);
        step(0, 0, 0, 1);
        check("obs_no_effect_up", 1, 0);
        step(0, 1, 0, 0);
        check("obs_stop_top", 0, 0);
        step(1, 1, 0, 1);
        check("obs_blocks_down", 0, 0);
        step(1, 0, 1, 1);
        check("obs_allows_up", 1, 0);
`endif

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit a, u, d, o;
            a = ($urandom_range(0, 3) == 0);
            u = ($urandom_range(0, 9) == 0);
            d = ($urandom_range(0, 9) == 0);
`ifdef GARAGE_OBSTRUCT_EN
            o = ($urandom_range(0, 11) == 0);
`else
            o = 1'b0;
`endif
            step(a, u, d, o);
            model_step(a, u, d, o);
            check("random", m_dir == 1, m_dir == -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
